dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I MEM stage: valid/ready request, fixed wait
// states, then a held response carrying the extended load data or an error flag.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr, lat_wdata;
  logic [31:0] mem [DEPTH];

  logic        accept, do_acc;
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr, acc_wdata;
  logic [AW-1:0] idx;
  logic [31:0] word, shifted, load_data, acc_rdata, wval;
  logic [15:0] half;
  logic [7:0]  bval;
  logic [3:0]  wmask;
  logic        bad_f3, misal, err;
  logic        unused_addr;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the accept edge, straight off the request.
  assign acc_we    = (WAIT_CYCLES == 0) ? req_we     : lat_we;
  assign acc_f3    = (WAIT_CYCLES == 0) ? req_funct3 : lat_f3;
  assign acc_addr  = (WAIT_CYCLES == 0) ? req_addr   : lat_addr;
  assign acc_wdata = (WAIT_CYCLES == 0) ? req_wdata  : lat_wdata;
  assign do_acc    = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd1);

  assign idx         = acc_addr[AW+1:2];
  assign unused_addr = ^acc_addr[31:AW+2];
  assign word        = mem[idx];
  assign shifted     = word >> {acc_addr[1:0], 3'b000};
  assign bval        = shifted[7:0];
  assign half        = acc_addr[1] ? word[31:16] : word[15:0];

  assign bad_f3 = acc_we ? (acc_f3[2] || acc_f3[1:0] == 2'b11)
                         : (acc_f3 == 3'b011 || acc_f3[2:1] == 2'b11);
  assign misal  = (acc_f3[1:0] == 2'b01 && acc_addr[0]) ||
                  (acc_f3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
  assign err    = bad_f3 || misal;

  always_comb begin
    load_data = 32'd0;
    case (acc_f3)
      3'b000:  load_data = {{24{bval[7]}}, bval};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, bval};
      3'b101:  load_data = {16'd0, half};
      default: load_data = 32'd0;
    endcase
  end

  assign acc_rdata = (err || acc_we) ? 32'd0 : load_data;

  always_comb begin
    wmask = 4'b1111;
    wval  = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin wmask = 4'b0001 << acc_addr[1:0]; wval = {4{acc_wdata[7:0]}};  end
      2'b01: begin wmask = acc_addr[1] ? 4'b1100 : 4'b0011; wval = {2{acc_wdata[15:0]}}; end
      default: ;
    endcase
  end

  // Storage is not reset; gating on rst keeps a store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (do_acc && acc_we && !err && rst)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[idx][8*i +: 8] <= wval[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_f3    <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we    <= req_we;
          lat_f3    <= req_funct3;
          lat_addr  <= req_addr;
          lat_wdata <= req_wdata;
          cnt       <= 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= err;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_rdata;
            rsp_err   <= err;
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
